motor_ctrl_multi: RTL and testbench

Parametrised motor controller that succeeds the single-servo / free-running-stepper counter block. It drives NUM_SERVOS RC-servo PWM channels with per-channel 8-bit position and glitch-free frame-synchronous updates. It also drives one 28BYJ-48-class unipolar stepper under a valid/ready move-command interface, with direction, step count, step period, half/full-step mode, abort and a signed position tracker. It sits between the board-level control logic and the motor pins.

---
 rtl/motor_ctrl_multi_pkg.sv | 22 ++
 rtl/motor_ctrl_multi_if.sv | 23 ++
 rtl/motor_ctrl_multi_servo_pwm_ch.sv | 43 ++++
 rtl/motor_ctrl_multi.sv | 169 ++++++++++++++++
 tb/tb_motor_ctrl_multi.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_ctrl_multi_pkg.sv
// Shared types and constants for the multi-servo / stepper motor controller:
// phase table, stepper FSM states and the servo tick divider.
package motor_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stepState_t;

  // Half-step sequence, entry 0 in the least significant nibble.
  localparam logic [31:0] PHASE_TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                         4'b0110, 4'b0100, 4'b1100, 4'b1000};

  function automatic int tickDiv(input int clkHz);
    return (clkHz / 256000 > 0) ? clkHz / 256000 : 1;
  endfunction

  function automatic logic [3:0] phasePins(input logic [2:0] idx);
    return PHASE_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/motor_ctrl_multi_if.sv
// Stepper move-command channel: valid/ready command fields plus abort.
interface motor_ctrl_multi_if #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 24
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [STEP_W-1:0]   cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;
  logic                cmd_half;
  logic                abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_half, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_half, abort,
    output cmd_ready
  );
endinterface

// File: rtl/motor_ctrl_multi_servo_pwm_ch.sv
// One RC-servo channel: position/enable latched at frame start, registered
// comparator output so mid-frame input changes never reshape a pulse.
module servo_pwm_ch (
  input  logic        clock,
  input  logic        reset,
  input  logic        frameStart,
  input  logic [11:0] tickCnt,
  input  logic [7:0]  pos,
  input  logic        en,
  output logic        pin
);
  logic [7:0] posLat_r;
  logic       enLat_r;
  logic       pin_r;
  logic [7:0] posSel_s;
  logic       enSel_s;

  // On the frame-start cycle compare against the incoming values being latched.
  always_comb begin
    if (frameStart) begin
      posSel_s = pos;
      enSel_s  = en;
    end else begin
      posSel_s = posLat_r;
      enSel_s  = enLat_r;
    end
  end

  // Frame latch and registered pulse compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      posLat_r <= 8'd0;
      enLat_r  <= 1'b0;
      pin_r    <= 1'b0;
    end else begin
      posLat_r <= posSel_s;
      enLat_r  <= enSel_s;
      pin_r    <= enSel_s & (tickCnt < {4'b0001, posSel_s});
    end
  end

  assign pin = pin_r;
endmodule

// File: rtl/motor_ctrl_multi.sv
// Multi-channel RC-servo PWM plus a command-driven unipolar stepper with
// abort and a signed position tracker.
module motor_ctrl_multi
  import motor_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int NUM_SERVOS = 4,
  parameter int STEP_W     = 16,
  parameter int PERIOD_W   = 24,
  parameter int POS_W      = 24,
  parameter bit HOLD       = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [8*NUM_SERVOS-1:0] servo_pos,
  input  logic [NUM_SERVOS-1:0]   servo_en,
  output logic [NUM_SERVOS-1:0]   servo_pins,
  motor_ctrl_multi_if.slave       cmdIf,
  output logic [3:0]              stepper_pins,
  output logic                    busy,
  output logic                    done,
  output logic [POS_W-1:0]        position
);
  localparam int            TDIV     = tickDiv(CLK_HZ);
  localparam int            CW       = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(TDIV - 1);

  logic [CW-1:0] clkCnt_r;
  logic [11:0]   tickCnt_r;
  logic          frameStart_s;

  // Servo tick generator; tickCnt wraps every 4096 ticks to form the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      clkCnt_r  <= '0;
      tickCnt_r <= 12'd0;
    end else if (clkCnt_r == CLK_LAST) begin
      clkCnt_r  <= '0;
      tickCnt_r <= tickCnt_r + 12'd1;
    end else begin
      clkCnt_r  <= clkCnt_r + CW'(1);
    end
  end

  assign frameStart_s = (tickCnt_r == 12'd0) && (clkCnt_r == '0);

  for (genvar i = 0; i < NUM_SERVOS; i++) begin : gCh
    servo_pwm_ch uCh (
      .clock      (clock),
      .reset      (reset),
      .frameStart (frameStart_s),
      .tickCnt    (tickCnt_r),
      .pos        (servo_pos[8*i +: 8]),
      .en         (servo_en[i]),
      .pin        (servo_pins[i])
    );
  end

  stepState_t          state_r, state_s;
  logic [2:0]          phase_r, phase_s, stride_s;
  logic [POS_W-1:0]    position_r, position_s;
  logic [STEP_W-1:0]   remaining_r, remaining_s;
  logic [PERIOD_W-1:0] perCnt_r, perCnt_s, perLast_r, perLast_s;
  logic                dir_r, dir_s, half_r, half_s;
  logic                done_r, done_s, busy_r, busy_s, ready_r, ready_s;
  logic [3:0]          pins_r, pins_s;
  logic                stepNow_s;

  // Stepper state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      phase_r     <= 3'd0;
      position_r  <= '0;
      remaining_r <= '0;
      perCnt_r    <= '0;
      perLast_r   <= '0;
      dir_r       <= 1'b0;
      half_r      <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
      pins_r      <= 4'b0000;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      position_r  <= position_s;
      remaining_r <= remaining_s;
      perCnt_r    <= perCnt_s;
      perLast_r   <= perLast_s;
      dir_r       <= dir_s;
      half_r      <= half_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      ready_r     <= ready_s;
      pins_r      <= pins_s;
    end
  end

  // Next-state logic: command accept, step timing, completion and abort.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    position_s  = position_r;
    remaining_s = remaining_r;
    perCnt_s    = perCnt_r;
    perLast_s   = perLast_r;
    dir_s       = dir_r;
    half_s      = half_r;
    done_s      = 1'b0;
    stepNow_s   = 1'b0;
    stride_s    = half_r ? 3'd1 : 3'd2;
    case (state_r)
      IDLE: begin
        if (cmdIf.cmd_valid && (cmdIf.cmd_steps != '0)) begin
          dir_s       = cmdIf.cmd_dir;
          half_s      = cmdIf.cmd_half;
          remaining_s = cmdIf.cmd_steps;
          perCnt_s    = '0;
          perLast_s   = (cmdIf.cmd_period == '0) ? '0 : cmdIf.cmd_period - PERIOD_W'(1);
          phase_s     = cmdIf.cmd_half ? phase_r : {phase_r[2:1], 1'b0};
          state_s     = RUN;
        end else if (cmdIf.cmd_valid) begin
          done_s      = 1'b1;
        end else begin
          state_s     = IDLE;
        end
      end
      RUN: begin
        stepNow_s = (perCnt_r == perLast_r);
        if (stepNow_s) begin
          phase_s     = dir_r ? phase_r + stride_s : phase_r - stride_s;
          position_s  = dir_r ? position_r + POS_W'(1) : position_r - POS_W'(1);
          remaining_s = remaining_r - STEP_W'(1);
          perCnt_s    = '0;
        end else begin
          perCnt_s    = perCnt_r + PERIOD_W'(1);
        end
        // A step landing in the abort cycle is still taken.
        if ((stepNow_s && (remaining_r == STEP_W'(1))) || cmdIf.abort) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    busy_s  = (state_s == RUN);
    ready_s = (state_s == IDLE);
    if ((state_s == RUN) || HOLD) begin
      pins_s = phasePins(phase_s);
    end else begin
      pins_s = 4'b0000;
    end
  end

  assign cmdIf.cmd_ready = ready_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign position        = position_r;
  assign stepper_pins    = pins_r;
endmodule

// File: tb/tb_motor_ctrl_multi.sv
// Directed bench for motor_ctrl_multi: servo pulse widths and stepper moves
// checked against a bench-side model via a scoreboard queue.
module tb_motor_ctrl_multi;
  localparam int CLK_HZ = 512000;
  localparam int TDIV   = 2;
  localparam int FRAME  = 4096 * TDIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] servo_pos;
  logic [3:0]  servo_en;
  logic [3:0]  servoPins, servoPinsH, stepperPins, stepperPinsH;
  logic        busy, busyH, done, doneH;
  logic [23:0] position, positionH;

  int passCnt  = 0;
  int checkCnt = 0;
  int failCnt  = 0;

  typedef struct {
    string      tag;
    logic [23:0] pos;
    int         busyCyc;
    int         firstAt;
    logic [3:0] holdPins;
  } exp_t;
  exp_t sbq[$];
  int   q0[$];
  int   q1[$];
  int   mPos   = 0;
  int   mPhase = 0;

  motor_ctrl_multi_if #(.STEP_W(16), .PERIOD_W(24)) cIf ();
  motor_ctrl_multi_if #(.STEP_W(16), .PERIOD_W(24)) cIfH ();

  assign cIfH.cmd_valid  = cIf.cmd_valid;
  assign cIfH.cmd_dir    = cIf.cmd_dir;
  assign cIfH.cmd_steps  = cIf.cmd_steps;
  assign cIfH.cmd_period = cIf.cmd_period;
  assign cIfH.cmd_half   = cIf.cmd_half;
  assign cIfH.abort      = cIf.abort;

  motor_ctrl_multi #(.CLK_HZ(CLK_HZ), .NUM_SERVOS(4), .STEP_W(16), .PERIOD_W(24),
                     .POS_W(24), .HOLD(1'b0)) dut (
    .clock(clock), .reset(reset), .servo_pos(servo_pos), .servo_en(servo_en),
    .servo_pins(servoPins), .cmdIf(cIf.slave), .stepper_pins(stepperPins),
    .busy(busy), .done(done), .position(position)
  );

  motor_ctrl_multi #(.CLK_HZ(CLK_HZ), .NUM_SERVOS(4), .STEP_W(16), .PERIOD_W(24),
                     .POS_W(24), .HOLD(1'b1)) dutHold (
    .clock(clock), .reset(reset), .servo_pos(servo_pos), .servo_en(servo_en),
    .servo_pins(servoPinsH), .cmdIf(cIfH.slave), .stepper_pins(stepperPinsH),
    .busy(busyH), .done(doneH), .position(positionH)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] tablePins(input int idx);
    case (idx)
      0: return 4'b1000;
      1: return 4'b1100;
      2: return 4'b0100;
      3: return 4'b0110;
      4: return 4'b0010;
      5: return 4'b0011;
      6: return 4'b0001;
      7: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checkCnt++;
    assert (obs === expv) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Caller is at a negedge; drives the command and records the expected outcome.
  task automatic startCmd(input logic dir, input int steps, input int period,
                          input logic half, input int abortAt, input string tag);
    exp_t e;
    int eff, taken, st;
    eff   = (period == 0) ? 1 : period;
    taken = (abortAt == 0) ? steps : ((abortAt / eff < steps) ? abortAt / eff : steps);
    st    = half ? 1 : 2;
    if (steps != 0 && !half) mPhase = mPhase & 6;
    for (int k = 0; k < taken; k++) begin
      mPhase = (mPhase + (dir ? st : 8 - st)) % 8;
      mPos   = dir ? mPos + 1 : mPos - 1;
    end
    e.tag      = tag;
    e.pos      = mPos[23:0];
    e.busyCyc  = (steps == 0) ? 0 : ((abortAt == 0) ? steps * eff : abortAt);
    e.firstAt  = (taken > 0) ? eff + 1 : 0;
    e.holdPins = tablePins(mPhase);
    sbq.push_back(e);
    check({tag, "_ready"}, cIf.cmd_ready, 1);
    cIf.cmd_valid  = 1'b1;
    cIf.cmd_dir    = dir;
    cIf.cmd_steps  = 16'(steps);
    cIf.cmd_period = 24'(period);
    cIf.cmd_half   = half;
  endtask

  // Completes the transfer, runs until done (bounded) and scores the result.
  task automatic finishMove(input int abortAt);
    exp_t e;
    int busyCnt, firstAt;
    logic got;
    logic [23:0] startPos;
    busyCnt  = 0;
    firstAt  = 0;
    got      = 1'b0;
    startPos = position;
    @(posedge clock);
    #1;
    cIf.cmd_valid  = 1'b0;
    cIf.cmd_steps  = 16'($urandom);
    cIf.cmd_period = 24'($urandom);
    cIf.cmd_dir    = 1'($urandom);
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        if (firstAt == 0 && position !== startPos) firstAt = busyCnt + 1;
      end else begin
        if (busy) busyCnt++;
        if (busyCnt == 1 && busy) check("ready_low_busy", cIf.cmd_ready, 0);
        if (firstAt == 0 && position !== startPos) firstAt = busyCnt;
        cIf.abort = (abortAt != 0) && (busyCnt == abortAt);
      end
    end
    cIf.abort = 1'b0;
    e = sbq.pop_front();
    check({e.tag, "_done_seen"}, got, 1);
    check({e.tag, "_busy_excl"}, busy, 0);
    check({e.tag, "_position"}, position, e.pos);
    check({e.tag, "_busy_cycles"}, busyCnt, e.busyCyc);
    check({e.tag, "_first_step"}, firstAt, e.firstAt);
    check({e.tag, "_idle_pins"}, stepperPins, 4'b0000);
    check({e.tag, "_hold_pins"}, stepperPinsH, e.holdPins);
    check({e.tag, "_hold_pos"}, positionH, e.pos);
    check({e.tag, "_hold_flags"}, {busyH, doneH}, 2'b01);
  endtask

  task automatic runMove(input logic dir, input int steps, input int period,
                         input logic half, input int abortAt, input string tag);
    @(negedge clock);
    startCmd(dir, steps, period, half, abortAt, tag);
    finishMove(abortAt);
    @(negedge clock);
    check({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    int p0, p1, w0, w1, hi23, rise0;
    cIf.cmd_valid  = 1'b0;
    cIf.cmd_dir    = 1'b0;
    cIf.cmd_steps  = 16'd0;
    cIf.cmd_period = 24'd0;
    cIf.cmd_half   = 1'b0;
    cIf.abort      = 1'b0;
    servo_pos = {8'd0, 8'd200, 8'd255, 8'd0};
    servo_en  = 4'b0011;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_servo", servoPins, 4'b0000);
    check("rst_pins", stepperPins, 4'b0000);
    check("rst_pins_hold", stepperPinsH, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cIf.cmd_ready, 1);
    check("rst_position", position, 0);

    // Servo: two frames, ch0 position changed mid-frame.
    q0.push_back(256 * TDIV);
    q1.push_back(511 * TDIV);
    q1.push_back(511 * TDIV);
    p0 = 0; p1 = 0; w0 = 0; w1 = 0; hi23 = 0; rise0 = -1;
    for (int cyc = 0; cyc < FRAME + 1300; cyc++) begin
      @(negedge clock);
      if (cyc == 200) begin
        servo_pos[7:0] = 8'd128;
        q0.push_back(384 * TDIV);
      end
      if (servoPins[0]) w0++;
      if (servoPins[1]) w1++;
      if (servoPins[3:2] != 2'b00 || servoPinsH[3:2] != 2'b00) hi23++;
      if (servoPins[0] && p0 == 0) begin
        if (rise0 >= 0) check("ch0_frame_period", cyc - rise0, FRAME);
        rise0 = cyc;
      end
      if (!servoPins[0] && p0 == 1) begin
        if (q0.size() == 0) check("ch0_extra_pulse", 1, 0);
        else check("ch0_width", w0, q0.pop_front());
        w0 = 0;
      end
      if (!servoPins[1] && p1 == 1) begin
        if (q1.size() == 0) check("ch1_extra_pulse", 1, 0);
        else check("ch1_width", w1, q1.pop_front());
        w1 = 0;
      end
      p0 = int'(servoPins[0]);
      p1 = int'(servoPins[1]);
    end
    check("ch0_pulses_left", q0.size(), 0);
    check("ch1_pulses_left", q1.size(), 0);
    check("disabled_low", hi23, 0);

    // Abort while idle is ignored.
    @(negedge clock);
    cIf.abort = 1'b1;
    @(negedge clock);
    cIf.abort = 1'b0;
    check("idle_abort_done", done, 0);
    check("idle_abort_busy", busy, 0);

    runMove(1'b1, 10, 4, 1'b1, 0, "half_fwd10");
    runMove(1'b1, 3, 2, 1'b1, 0, "half_fwd3");
    runMove(1'b0, 3, 1, 1'b0, 0, "full_rev3");
    runMove(1'b1, 2, 0, 1'b0, 0, "period0");

    // Abort after two steps, then a zero-step command taken in the done cycle.
    @(negedge clock);
    startCmd(1'b1, 5, 3, 1'b1, 7, "abort2of5");
    finishMove(7);
    check("b2b_done_high", done, 1);
    startCmd(1'b0, 0, 5, 1'b0, 0, "zero_steps");
    finishMove(0);
    @(negedge clock);
    check("zero_done_width", done, 0);
    check("zero_busy_low", busy, 0);

    runMove(1'b0, 4, 2, 1'b0, 4, "abort_on_step");
    runMove(1'b0, 15, 1, 1'b1, 0, "half_rev15");

    // Reset in the middle of a move.
    @(negedge clock);
    startCmd(1'b1, 20, 2, 1'b1, 0, "mid_reset");
    @(posedge clock);
    #1 cIf.cmd_valid = 1'b0;
    repeat (10) @(negedge clock);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mreset_busy", busy, 0);
    check("mreset_done", done, 0);
    check("mreset_position", position, 0);
    check("mreset_pins", stepperPins, 4'b0000);
    check("mreset_pins_hold", stepperPinsH, 4'b0000);
    check("mreset_ready", cIf.cmd_ready, 1);
    check("mreset_servo", servoPins, 4'b0000);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("mreset_no_done", {done, busy}, 2'b00);
    end
    sbq.delete();
    mPos   = 0;
    mPhase = 0;
    check("mreset_idle_pins", stepperPins, 4'b0000);
    check("mreset_hold_pins", stepperPinsH, 4'b1000);

    runMove(1'b1, 1, 1, 1'b0, 0, "post_reset");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
